// File: rtl/alu_pkg.sv
// Shared constants and enums for the two-requester ALU arbiter.
// Opcode values are the select codes carried on the request ports.
package alu_pkg;

    localparam int W         = 9;
    localparam int SELW      = 4;
    localparam int MUL_STEPS = 9;

    typedef enum logic [SELW-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_DECB  = 4'd2,
        OP_MUL   = 4'd3,
        OP_LAND  = 4'd4,
        OP_LOR   = 4'd5,
        OP_LNOT  = 4'd6,
        OP_NOT   = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_XOR   = 4'd10,
        OP_SHL   = 4'd11,
        OP_SHR   = 4'd12,
        OP_INC   = 4'd13,
        OP_DEC   = 4'd14,
        OP_PASSB = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU. MUL is handled by the iterative
// datapath in the arbiter, so its opcode yields zero here.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::W
) (
    input  logic [SELW-1:0] sel,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    z
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        z = '0;
        case (op_e'(sel))
            OP_ADD:   z = a + b;
            OP_SUB:   z = a - b;
            OP_DECB:  z = b - ONE;
            OP_MUL:   z = '0;
            OP_LAND:  z = {{(W-1){1'b0}}, (|a) && (|b)};
            OP_LOR:   z = {{(W-1){1'b0}}, (|a) || (|b)};
            OP_LNOT:  z = {{(W-1){1'b0}}, ~(|a)};
            OP_NOT:   z = ~a;
            OP_AND:   z = a & b;
            OP_OR:    z = a | b;
            OP_XOR:   z = a ^ b;
            OP_SHL:   z = {a[W-2:0], 1'b0};
            OP_SHR:   z = {1'b0, a[W-1:1]};
            OP_INC:   z = a + ONE;
            OP_DEC:   z = a - ONE;
            OP_PASSB: z = b;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// 9-step shift-add multiplier and a registered valid/ready response port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W    = alu_pkg::W,
    parameter int SELW = alu_pkg::SELW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SELW-1:0] req0_sel,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SELW-1:0] req1_sel,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_z,
    output logic            busy
);

    // Handshake: a request transfers on a clock edge where reqN_valid and
    // reqN_ready are both 1; the response transfers where rsp_valid and
    // rsp_ready are both 1. reqN_ready is a function of both valids, so
    // requesters must raise valid without looking at ready.

    state_e          state, state_nx;
    logic            last;
    logic            grant, any_valid, accept_ok, accept, is_mul, mul_last;
    logic [SELW-1:0] g_sel;
    logic [W-1:0]    g_a, g_b, core_z;
    logic [W-1:0]    mcand, mplier, acc, acc_nx;
    logic [3:0]      step;
    logic            mul_id;

    // Both active: the one not granted last time wins; otherwise the only active one.
    assign any_valid = req0_valid | req1_valid;
    assign grant     = (req0_valid && req1_valid) ? ~last : req1_valid;
    assign accept_ok = !reset && ((state == ST_IDLE) || (state == ST_HOLD && rsp_ready));
    assign accept    = accept_ok && any_valid;

    assign g_sel  = grant ? req1_sel : req0_sel;
    assign g_a    = grant ? req1_a   : req0_a;
    assign g_b    = grant ? req1_b   : req0_b;
    assign is_mul = (g_sel == OP_MUL);

    assign mul_last = (step == 4'(MUL_STEPS - 1));
    assign acc_nx   = acc + (mplier[0] ? mcand : '0);

    alu_core #(.W(W)) u_core (
        .sel (g_sel),
        .a   (g_a),
        .b   (g_b),
        .z   (core_z)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = is_mul ? ST_MUL : ST_HOLD;
            ST_MUL:  if (mul_last) state_nx = ST_HOLD;
            ST_HOLD: begin
                if (accept)         state_nx = is_mul ? ST_MUL : ST_HOLD;
                else if (rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        rsp_valid  = (state == ST_HOLD);
        busy       = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_z  <= '0;
            rsp_id <= 1'b0;
            last   <= 1'b1;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            step   <= '0;
            mul_id <= 1'b0;
        end else begin
            if (accept) begin
                last <= grant;
                if (is_mul) begin
                    mcand  <= g_a;
                    mplier <= g_b;
                    acc    <= '0;
                    step   <= '0;
                    mul_id <= grant;
                end else begin
                    rsp_z  <= core_z;
                    rsp_id <= grant;
                end
            end
            // Response register is only touched once the product is complete.
            if (state == ST_MUL) begin
                acc    <= acc_nx;
                mcand  <= {mcand[W-2:0], 1'b0};
                mplier <= {1'b0, mplier[W-1:1]};
                step   <= step + 4'd1;
                if (mul_last) begin
                    rsp_z  <= acc_nx;
                    rsp_id <= mul_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of grants, latencies and results.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_sel, req1_sel;
    logic [8:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [8:0] rsp_z;

    int vectors = 0;
    int miscompares = 0;
    int model_last;
    logic [9:0] exp_q[$];

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_sel   (req0_sel),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_sel   (req1_sel),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference ALU in plain integer arithmetic, reduced mod 512.
    function automatic logic [8:0] ref_alu(input int sel, input int a, input int b);
        int r;
        case (sel)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = b - 1;
            3:  r = a * b;
            4:  r = (a != 0 && b != 0) ? 1 : 0;
            5:  r = (a != 0 || b != 0) ? 1 : 0;
            6:  r = (a == 0) ? 1 : 0;
            7:  r = 511 - a;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = a * 2;
            12: r = a / 2;
            13: r = a + 1;
            14: r = a - 1;
            default: r = b;
        endcase
        return 9'(r & 511);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input int sel, input int a, input int b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_sel = 4'(sel); req0_a = 9'(a); req0_b = 9'(b);
        end else begin
            req1_valid = 1'b1; req1_sel = 4'(sel); req1_a = 9'(a); req1_b = 9'(b);
        end
    endtask

    task automatic clear_reqs;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 0, 1, 1);
        set_req(1, 0, 1, 1);
        tick;
        tick;
        vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_z !== 9'd0) begin miscompares++; $display("FAIL reset_rsp_z: got %0d want 0", rsp_z); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        rsp_ready = 1'b0;
        clear_reqs;
        model_last = 1;
        tick;
    endtask

    task automatic test_single_add;
        set_req(0, 0, 200, 400);
        #1;
        vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL add_ready: got %b want 01", {req1_ready, req0_ready}); end
        tick;
        clear_reqs;
        model_last = 0;
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: rsp_valid got %b want 1", rsp_valid); end
        vectors++; if (rsp_z !== 9'd88) begin miscompares++; $display("FAIL add_z: got %0d want 88", rsp_z); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL add_id: got %b want 0", rsp_id); end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL add_release: valid/busy got %b%b want 00", rsp_valid, busy); end
    endtask

    task automatic test_sub_logic;
        int sel_t[4] = '{1, 6, 4, 12};
        int a_t[4]   = '{3, 0, 4, 511};
        int b_t[4]   = '{5, 0, 0, 0};
        int z_t[4]   = '{510, 1, 0, 255};
        for (int i = 0; i < 4; i++) begin
            set_req(i % 2, sel_t[i], a_t[i], b_t[i]);
            tick;
            clear_reqs;
            model_last = i % 2;
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL logic_valid[%0d]: got %b want 1", i, rsp_valid); end
            vectors++; if (rsp_z !== 9'(z_t[i])) begin miscompares++; $display("FAIL logic_z[%0d]: got %0d want %0d", i, rsp_z, z_t[i]); end
            vectors++; if (rsp_id !== 1'(i % 2)) begin miscompares++; $display("FAIL logic_id[%0d]: got %b want %0d", i, rsp_id, i % 2); end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_contention;
        int a0, a1, g, prev_g;
        a0 = $urandom_range(0, 511);
        a1 = $urandom_range(0, 511);
        rsp_ready = 1'b1;
        set_req(0, 13, a0, 0);
        set_req(1, 13, a1, 0);
        prev_g = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            g = 1 - model_last;
            vectors++; if ({req1_ready, req0_ready} !== (g == 1 ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL contention_grant[%0d]: got %b want grant %0d", i, {req1_ready, req0_ready}, g); end
            if (i > 0) begin
                vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 1'(prev_g)) begin miscompares++; $display("FAIL contention_rsp[%0d]: valid/id got %b/%b want 1/%0d", i, rsp_valid, rsp_id, prev_g); end
                vectors++; if (rsp_z !== ref_alu(13, (prev_g == 1) ? a1 : a0, 0)) begin miscompares++; $display("FAIL contention_z[%0d]: got %0d want %0d", i, rsp_z, ref_alu(13, (prev_g == 1) ? a1 : a0, 0)); end
            end
            tick;
            model_last = g;
            prev_g = g;
        end
        clear_reqs;
        vectors++; if (rsp_z !== ref_alu(13, (prev_g == 1) ? a1 : a0, 0)) begin miscompares++; $display("FAIL contention_final_z: got %0d want %0d", rsp_z, ref_alu(13, (prev_g == 1) ? a1 : a0, 0)); end
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_mul;
        int lat;
        set_req(1, 3, 25, 30);
        #1;
        vectors++; if ({req1_ready, req0_ready} !== 2'b10) begin miscompares++; $display("FAIL mul_accept: got %b want 10", {req1_ready, req0_ready}); end
        tick;
        clear_reqs;
        model_last = 1;
        set_req(0, 13, 7, 0);
        set_req(1, 15, 0, 99);
        rsp_ready = 1'b1;
        lat = 1;
        #1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL mul_ready_busy[%0d]: got %b want 00", lat, {req1_ready, req0_ready}); end
            tick;
            lat++;
        end
        vectors++; if (lat != 10) begin miscompares++; $display("FAIL mul_latency: got %0d want 10", lat); end
        vectors++; if (rsp_z !== 9'd238 || rsp_id !== 1'b1) begin miscompares++; $display("FAIL mul_result: z/id got %0d/%b want 238/1", rsp_z, rsp_id); end
        vectors++; if ({req1_ready, req0_ready} !== 2'b01) begin miscompares++; $display("FAIL mul_b2b_grant: got %b want 01", {req1_ready, req0_ready}); end
        tick;
        clear_reqs;
        model_last = 0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_z !== 9'd8 || rsp_id !== 1'b0) begin miscompares++; $display("FAIL mul_b2b_rsp: valid/z/id got %b/%0d/%b want 1/8/0", rsp_valid, rsp_z, rsp_id); end
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int a, b, c, d;
        logic [8:0] exp0;
        a = $urandom_range(0, 511); b = $urandom_range(0, 511);
        c = $urandom_range(0, 511); d = $urandom_range(0, 511);
        exp0 = ref_alu(10, a, b);
        set_req(0, 10, a, b);
        tick;
        clear_reqs;
        model_last = 0;
        set_req(1, 0, c, d);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_z !== exp0 || rsp_id !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d]: valid/z/id got %b/%0d/%b want 1/%0d/0", i, rsp_valid, rsp_z, rsp_id, exp0); end
            vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req1_ready, req0_ready}); end
            tick;
        end
        rsp_ready = 1'b1;
        #1;
        vectors++; if ({req1_ready, req0_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_release_accept: got %b want 10", {req1_ready, req0_ready}); end
        tick;
        clear_reqs;
        model_last = 1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_z !== ref_alu(0, c, d) || rsp_id !== 1'b1) begin miscompares++; $display("FAIL bp_next: valid/z/id got %b/%0d/%b want 1/%0d/1", rsp_valid, rsp_z, rsp_id, ref_alu(0, c, d)); end
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        set_req(0, 3, $urandom_range(1, 511), $urandom_range(1, 511));
        tick;
        clear_reqs;
        tick; tick; tick;
        reset = 1'b1;
        set_req(1, 0, 5, 5);
        #1;
        vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_mul_ready: got %b want 00", {req1_ready, req0_ready}); end
        tick;
        reset = 1'b0;
        clear_reqs;
        model_last = 1;
        vectors++; if (rsp_valid !== 1'b0 || rsp_z !== 9'd0 || rsp_id !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mul_outputs: valid/z/id/busy got %b/%0d/%b/%b want 0/0/0/0", rsp_valid, rsp_z, rsp_id, busy); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid === 1'b1) seen++;
            tick;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_mul_no_rsp: got %0d response cycles want 0", seen); end
        set_req(0, 0, 1, 1);
        #1;
        vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rst_add_ready: got %b want 1", req0_ready); end
        tick;
        clear_reqs;
        model_last = 0;
        vectors++; if (rsp_valid !== 1'b1 || rsp_z !== 9'd2 || rsp_id !== 1'b0) begin miscompares++; $display("FAIL rst_add_rsp: valid/z/id got %b/%0d/%b want 1/2/0", rsp_valid, rsp_z, rsp_id); end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    // Random traffic checked against a transaction model: a one-deep
    // response slot, a countdown for multiplies and a round-robin pointer.
    task automatic test_random;
        logic pv[2];
        int ps[2], pa[2], pb[2];
        int g, mul_left;
        logic rsp_full, acc_ok;
        logic [1:0] exp_rdy;
        pv[0] = 1'b0; pv[1] = 1'b0;
        mul_left = 0;
        rsp_full = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pv[id] && cyc < 370 && $urandom_range(0, 2) != 0) begin
                    pv[id] = 1'b1;
                    ps[id] = $urandom_range(0, 15);
                    pa[id] = $urandom_range(0, 511);
                    pb[id] = $urandom_range(0, 511);
                end
            end
            if (pv[0]) set_req(0, ps[0], pa[0], pb[0]); else req0_valid = 1'b0;
            if (pv[1]) set_req(1, ps[1], pa[1], pb[1]); else req1_valid = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = (pv[0] && pv[1]) ? 1 - model_last : (pv[1] ? 1 : 0);
            acc_ok = (mul_left == 0) && (!rsp_full || rsp_ready) && (pv[0] || pv[1]);
            exp_rdy = acc_ok ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
            vectors++; if ({req1_ready, req0_ready} !== exp_rdy) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy); end
            vectors++; if (rsp_valid !== rsp_full) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b want %b", cyc, rsp_valid, rsp_full); end
            if (rsp_full) begin
                vectors++; if ({rsp_id, rsp_z} !== exp_q[0]) begin miscompares++; $display("FAIL rand_rsp[%0d]: id/z got %b/%0d want %b/%0d", cyc, rsp_id, rsp_z, exp_q[0][9], exp_q[0][8:0]); end
            end
            tick;
            if (rsp_full && rsp_ready) begin
                void'(exp_q.pop_front());
                rsp_full = 1'b0;
            end
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) rsp_full = 1'b1;
            end
            if (acc_ok) begin
                exp_q.push_back({1'(g), ref_alu(ps[g], pa[g], pb[g])});
                model_last = g;
                pv[g] = 1'b0;
                if (ps[g] == 3) mul_left = 9;
                else rsp_full = 1'b1;
            end
        end
        clear_reqs;
        rsp_ready = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand_drain_busy: got %b want 0", busy); end
    endtask

    initial begin
        clear_reqs;
        req0_sel = '0; req0_a = '0; req0_b = '0;
        req1_sel = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        test_reset;
        test_single_add;
        test_sub_logic;
        test_contention;
        test_mul;
        test_backpressure;
        test_reset_mid_mul;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and arbiter that shares one 9-bit, 16-operation ALU between two requesters. Each requester issues an operation (select code plus operands) over a valid/ready handshake. The block grants requests round-robin, runs single-cycle operations directly and multiply as a 9-step iterative shift-add, and returns one tagged result through a registered valid/ready response port. It sits between instruction-issue logic and the shared ALU datapath.

## Interface
- Parameters:
  - `W`, default 9: operand and result width.
  - `SELW`, default 4: operation select width. Fixed by the package; do not override.
- Ports (clock and reset first):
  - `clk`, input, 1: single clock. All state updates on the rising edge.
  - `reset`, input, 1: synchronous, active-high reset.
  - `req0_valid`, input, 1: requester 0 has an operation.
  - `req0_ready`, output, 1: requester 0's operation is accepted this cycle.
  - `req0_sel`, input, SELW: requester 0 opcode.
  - `req0_a`, `req0_b`, input, W each: requester 0 operands.
  - `req1_valid`, `req1_ready`, `req1_sel`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
  - `rsp_valid`, output, 1: result held in the response register.
  - `rsp_ready`, input, 1: consumer takes the result this cycle.
  - `rsp_id`, output, 1: index of the requester that issued the result.
  - `rsp_z`, output, W: result.
  - `busy`, output, 1: state is not IDLE.

## Operation
- Opcode encoding, all results truncated to W bits:
  - 0: ADD, a+b
  - 1: SUB, a−b
  - 2: DECB, b−1
  - 3: MUL, a*b, low W bits
  - 4: LAND, a&&b
  - 5: LOR, a||b
  - 6: LNOT, !a
  - 7: NOT, ~a
  - 8: AND
  - 9: OR
  - 10: XOR
  - 11: SHL, a<<1
  - 12: SHR, a>>1, logical
  - 13: INC, a+1
  - 14: DEC, a−1
  - 15: PASSB, b
- Logical operations (4, 5, 6) return 0 or 1, zero-extended to W bits.
- FSM states:
  - IDLE: no operation in flight, response register empty.
  - MUL: iterative multiply in progress.
  - HOLD: result in the response register, waiting for the consumer.
- Acceptance is allowed only in IDLE, or in HOLD in a cycle where `rsp_ready`=1 (back-to-back issue).
- Grant rules:
  - Round-robin pointer `last` holds the index of the last granted requester. Reset value is 1, so requester 0 wins the first tie.
  - Only one requester is active: it is granted.
  - Both are active: the requester ≠ `last` is granted.
  - `reqN_ready` is combinational from the valids, the state and `rsp_ready`. Requesters must not make valid depend on ready.
  - `last` updates only on an actual accept.
- Accept of a non-MUL opcode: the ALU result loads `rsp_z`, `rsp_id` = granted index, go to HOLD.
- Accept of MUL:
  - Latch multiplicand = a, multiplier = b. Clear the accumulator and step count.
  - Go to MUL.
  - Each step: if multiplier LSB is 1, accumulator += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1, all W bits wide.
  - After step 9, load the accumulator into `rsp_z` and go to HOLD.
- In HOLD:
  - `rsp_ready`=1 with no accept: go to IDLE, `rsp_valid` drops next cycle.
  - `rsp_ready`=1 with an accept: behave as an accept from IDLE.
- In MUL, both ready outputs are 0 and `rsp_ready` is ignored.
- Reset values: `rsp_valid`=0, `rsp_z`=0, `rsp_id`=0, `busy`=0, both ready outputs 0 during reset, state IDLE, `last`=1.
- Reset mid-MUL or in HOLD discards the operation. No response is produced.

## Timing
- Accept on the edge ending cycle N.
  - Non-MUL opcode: `rsp_valid`=1 in cycle N+1.
  - MUL: `rsp_valid`=1 in cycle N+10.
- Throughput:
  - Single-cycle ops: one per cycle while `rsp_ready` is held at 1.
  - MUL: one per 10 cycles.
- `rsp_z`/`rsp_id` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Requests stalled by backpressure are not dropped. Operands are sampled only at accept.

## Structure
- Package `alu_pkg`:
  - W and SELW localparams.
  - Opcode enum (16 values above).
  - FSM state enum.
- Sub-module `alu_core`: purely combinational, inputs sel/a/b, output z. It implements every opcode except MUL (returns 0 for opcode 3) and is instantiated once, fed by the granted requester's mux.
- The iterative multiplier datapath lives in `alu_arbiter`.

## Test plan
- Single ADD: req0 ADD a=200, b=400 -> `rsp_z`=88 (600 mod 512), `rsp_id`=0, `rsp_valid` one cycle after accept.
- SUB wrap plus logical ops:
  - SUB a=3, b=5 -> 510.
  - LNOT a=0 -> 1.
  - LAND a=4, b=0 -> 0.
  - SHR a=9'h1FF -> 255.
- MUL: req1 MUL a=25, b=30 -> 238 (750 mod 512), `rsp_valid` exactly 10 cycles after accept. Both ready outputs stay 0 throughout.
- Contention:
  - Both requesters hold INC continuously, `rsp_ready`=1.
  - Required: grants alternate 0,1,0,1 and results appear every cycle.
- Backpressure: `rsp_ready` held 0 for 5 cycles -> `rsp_z` stable, both ready outputs 0. On release, the next request is accepted in the same cycle.
- Reset mid-MUL: assert `reset` at step 4 -> all outputs return to reset values, no response. A following ADD 1+1 -> 2.
